bcd_scan_7seg: RTL and testbench

Multiplexed seven-segment display scanner that sits directly downstream of the chained BCD counter digits. It consumes their packed 4-bit `val` outputs, snapshots them on a load strobe, and time-multiplexes one digit at a time onto a shared segment bus. Each digit slot begins with a ghost-suppression blanking interval. Invalid BCD codes are shown as a dash; leading-zero blanking is optional at build time.

---
 rtl/bcd_scan_7seg_if.sv | 23 ++
 rtl/bcd_scan_7seg.sv | 121 ++++++++++++
 tb/tb_bcd_scan_7seg.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_7seg_if.sv
// Display-scanner bus: BCD digit snapshot inputs on one side, multiplexed
// segment/anode drive on the other.
interface bcd_scan_7seg_if #(
  parameter int NDIGITS = 4
);
  logic [4*NDIGITS-1:0] digits;
  logic                 load;
  logic [NDIGITS-1:0]   dp_mask;
  logic [6:0]           seg;
  logic                 dp;
  logic [NDIGITS-1:0]   an;
  logic                 slot_start;

  modport master (
    output digits, load, dp_mask,
    input  seg, dp, an, slot_start
  );

  modport slave (
    input  digits, load, dp_mask,
    output seg, dp, an, slot_start
  );
endinterface

// File: rtl/bcd_scan_7seg.sv
// Multiplexed seven-segment scanner with per-slot ghost blanking.
// Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_scan_7seg #(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 1024,
  parameter int GHOST    = 16
) (
  input logic           clk,
  input logic           reset,
  bcd_scan_7seg_if.slave bus
);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] GHOST_P = PRE_W'(GHOST);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIGITS - 1);

  typedef enum logic {BLANK, DRIVE} phase_t;

  phase_t               phase, phase_next;
  logic [PRE_W-1:0]     pre, pre_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [3:0]           snap [NDIGITS];
  logic [NDIGITS-1:0]   snap_dp;
  logic [6:0]           seg_q, seg_next;
  logic                 dp_q, dp_next;
  logic [NDIGITS-1:0]   an_q, an_next;
  logic                 lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    pre_next = pre + 1'b1;
    idx_next = idx;
    if (pre == PRE_MAX) begin
      pre_next = '0;
      idx_next = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

`ifdef BCD_SCAN_LZB_EN
  // A nonzero digit at or above the current one keeps it visible.
  always_comb begin
    lz_blank = (idx != '0);
    for (int j = 0; j < NDIGITS; j++) begin
      if (j >= int'(idx) && snap[j] != 4'd0) lz_blank = 1'b0;
    end
  end
`else
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // Pattern is taken from the pre-edge snapshot only on BLANK->DRIVE, so a
  // load during DRIVE cannot tear the lit digit.
  always_comb begin
    phase_next = (pre_next >= GHOST_P) ? DRIVE : BLANK;
    seg_next   = seg_q;
    dp_next    = dp_q;
    an_next    = an_q;
    case (phase_next)
      BLANK: begin
        seg_next = '0;
        dp_next  = 1'b0;
        an_next  = '0;
      end
      DRIVE: begin
        if (phase == BLANK) begin
          seg_next = lz_blank ? 7'h00 : decode(snap[idx]);
          dp_next  = snap_dp[idx];
          an_next  = NDIGITS'(1) << idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre     <= '0;
      idx     <= '0;
      phase   <= BLANK;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      an_q    <= '0;
      snap_dp <= '0;
      for (int i = 0; i < NDIGITS; i++) snap[i] <= 4'd0;
    end else begin
      pre   <= pre_next;
      idx   <= idx_next;
      phase <= phase_next;
      seg_q <= seg_next;
      dp_q  <= dp_next;
      an_q  <= an_next;
      if (bus.load) begin
        snap_dp <= bus.dp_mask;
        for (int i = 0; i < NDIGITS; i++) snap[i] <= bus.digits[4*i +: 4];
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.slot_start = (pre == '0) && !reset;
endmodule

// File: tb/tb_bcd_scan_7seg.sv
// Self-checking bench for bcd_scan_7seg against a cycle-count based model
// of the display (NDIGITS=4, SCAN_DIV=8, GHOST=2).
module tb_bcd_scan_7seg;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bcd_scan_7seg_if #(.NDIGITS(ND)) bus ();

  bcd_scan_7seg #(.NDIGITS(ND), .SCAN_DIV(SD), .GHOST(GH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int          cyc;
  logic [15:0] m_snap;
  logic [3:0]  m_mask;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic [12:0] got, want;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Expected {an, seg, dp, slot_start} for the current cycle number.
  function automatic logic [12:0] expect_now();
    int   p   = cyc % SD;
    int   idx = (cyc / SD) % ND;
    logic ss  = (p == 0);
    if (p < GH) return {4'b0000, 7'h00, 1'b0, ss};
    return {4'(1 << idx), m_seg, m_dp, ss};
  endfunction

  task automatic advance(input logic ld, input logic [15:0] d, input logic [3:0] m);
    int nc;
    int idx;
    bus.load    = ld;
    bus.digits  = d;
    bus.dp_mask = m;
    @(posedge clk);
    nc = cyc + 1;
    if (nc % SD == GH) begin
      idx   = (nc / SD) % ND;
      m_seg = seg_tab[m_snap[4*idx +: 4]];
      m_dp  = m_mask[idx];
`ifdef BCD_SCAN_LZB_EN
      if (idx > 0 && (m_snap >> (4*idx)) == 16'h0) m_seg = 7'h00;
`endif
    end
    if (ld) begin
      m_snap = d;
      m_mask = m;
    end
    cyc = nc;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    bus.load    = 1'b1;
    bus.digits  = 16'($urandom);
    bus.dp_mask = 4'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    cyc    = 0;
    m_snap = '0;
    m_mask = '0;
    m_seg  = '0;
    m_dp   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset    = 1'b1;
    bus.load = 1'b1;
    bus.digits = 16'h9876;
    @(posedge clk);
    @(negedge clk);
    #1;
    got = {bus.an, bus.seg, bus.dp, bus.slot_start};
    checks++;
    if (got !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h, want %h", got, 13'h0);
    end
    do_reset();
    for (int i = 0; i < 40; i++) begin
      want = expect_now();
      got  = {bus.an, bus.seg, bus.dp, bus.slot_start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL idle_scan cycle %0d: got %h, want %h", cyc, got, want);
      end
      advance(1'b0, 16'h0, 4'h0);
    end
  endtask

  task automatic test_digit_pattern();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      want = expect_now();
      got  = {bus.an, bus.seg, bus.dp, bus.slot_start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL pattern_1234 cycle %0d: got %h, want %h", cyc, got, want);
      end
      advance(i == 0, 16'h1234, 4'h0);
    end
  endtask

  task automatic test_dash_dp();
    do_reset();
    for (int i = 0; i < 72; i++) begin
      want = expect_now();
      got  = {bus.an, bus.seg, bus.dp, bus.slot_start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL dash_dp cycle %0d: got %h, want %h", cyc, got, want);
      end
      advance(i == 0, 16'h00A7, 4'b0010);
    end
  endtask

  task automatic test_no_tearing();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      want = expect_now();
      got  = {bus.an, bus.seg, bus.dp, bus.slot_start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL mid_drive_load cycle %0d: got %h, want %h", cyc, got, want);
      end
      if (i == 0)      advance(1'b1, 16'h1234, 4'h0);
      else if (i == 4) advance(1'b1, 16'h8765, 4'hF);
      else             advance(1'b0, 16'h0, 4'h0);
    end
    do_reset();
    for (int i = 0; i < 40; i++) begin
      want = expect_now();
      got  = {bus.an, bus.seg, bus.dp, bus.slot_start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL edge_load cycle %0d: got %h, want %h", cyc, got, want);
      end
      if (i == 0)      advance(1'b1, 16'h1234, 4'h0);
      else if (i == 1) advance(1'b1, 16'h8765, 4'h5);
      else             advance(1'b0, 16'h0, 4'h0);
    end
  endtask

  task automatic test_reset_mid_slot();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      want = expect_now();
      got  = {bus.an, bus.seg, bus.dp, bus.slot_start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL pre_reset cycle %0d: got %h, want %h", cyc, got, want);
      end
      advance(i == 0, 16'h5678, 4'hF);
    end
    reset       = 1'b1;
    bus.load    = 1'b1;
    bus.digits  = 16'h9999;
    bus.dp_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    #1;
    got = {bus.an, bus.seg, bus.dp, bus.slot_start};
    checks++;
    if (got !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_slot: got %h, want %h", got, 13'h0);
    end
    reset  = 1'b0;
    cyc    = 0;
    m_snap = '0;
    m_mask = '0;
    m_seg  = '0;
    m_dp   = 1'b0;
    #1;
    for (int i = 0; i < 40; i++) begin
      want = expect_now();
      got  = {bus.an, bus.seg, bus.dp, bus.slot_start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL post_reset cycle %0d: got %h, want %h", cyc, got, want);
      end
      advance(1'b0, 16'h0, 4'h0);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      want = expect_now();
      got  = {bus.an, bus.seg, bus.dp, bus.slot_start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h, want %h", cyc, got, want);
      end
      for (int k = 0; k < 4; k++)
        d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      advance($urandom_range(0, 9) == 0, d, 4'($urandom));
    end
  endtask

  initial begin
    bus.load    = 1'b0;
    bus.digits  = '0;
    bus.dp_mask = '0;
    test_reset();
    test_digit_pattern();
    test_dash_dp();
    test_no_tearing();
    test_reset_mid_slot();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
